// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl -- sequencing controller for the multi-cycle MIPS-lite datapath.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> MEM -> WB. Jumps and nop
// finish in DECODE, beq finishes in EXEC, sw finishes in MEM, and the rest
// finish in WB. One shared ALU and one memory port are used throughout.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   op, func   IR[31:26] / IR[5:0], valid from DECODE onward
//   zero       ALU zero flag for the current EXEC operands
//   mem_ready  data memory completion for the current access
//   ir_we, pc_we, pc_sel, reg_we, dst_sel, wd_sel   datapath writes / selects
//   alu_srcb, ext_sign, alu_ctrl                    ALU operand and operation
//   mem_req, mem_we, half                           data memory access
//   retire     one-cycle pulse on the final cycle of each instruction
//   state_o    current state (debug)
module multi_cycle_ctrl #(
    parameter int USE_MEM_READY = 1,
    parameter int JAL_REG       = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] dst_sel,
    output logic [1:0] wd_sel,
    output logic       alu_srcb,
    output logic       ext_sign,
    output logic [2:0] alu_ctrl,
    output logic       mem_req,
    output logic       mem_we,
    output logic       half,
    output logic       retire,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        I_UND, I_NOP, I_ADDU, I_SUBU, I_OR, I_JR,
        I_ORI, I_LUI, I_LW, I_LH, I_SW, I_BEQ, I_J, I_JAL
    } instr_e;

    state_e state, next;
    instr_e ins;
    logic   is_rtype;
    logic   mem_go;

    // The jal destination register is fixed in the datapath (dst_sel=2 selects
    // r31), so the parameter carries no logic of its own here.
    logic unused_jal_reg;
    assign unused_jal_reg = ^JAL_REG;

    assign mem_go  = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign state_o = state;

    // Instruction class from IR fields; anything unrecognised is I_UND and
    // retires in DECODE with no architectural effect.
    always_comb begin
        ins = I_UND;
        case (op)
            6'h00: begin
                case (func)
                    6'h00:   ins = I_NOP;
                    6'h08:   ins = I_JR;
                    6'h21:   ins = I_ADDU;
                    6'h23:   ins = I_SUBU;
                    6'h25:   ins = I_OR;
                    default: ins = I_UND;
                endcase
            end
            6'h02:   ins = I_J;
            6'h03:   ins = I_JAL;
            6'h04:   ins = I_BEQ;
            6'h0D:   ins = I_ORI;
            6'h0F:   ins = I_LUI;
            6'h21:   ins = I_LH;
            6'h23:   ins = I_LW;
            6'h2B:   ins = I_SW;
            default: ins = I_UND;
        endcase
    end

    assign is_rtype = (ins == I_ADDU) || (ins == I_SUBU) || (ins == I_OR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    always_comb begin
        next     = FETCH;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        reg_we   = 1'b0;
        dst_sel  = 2'd0;
        wd_sel   = 2'd0;
        alu_srcb = 1'b0;
        ext_sign = 1'b0;
        alu_ctrl = 3'b000;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        half     = 1'b0;
        retire   = 1'b0;
        // Outputs are held at 0 while reset is low, even though the state
        // register already reads FETCH.
        if (reset) begin
            case (state)
                FETCH: begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = 2'd0;
                    next   = DECODE;
                end
                DECODE: begin
                    case (ins)
                        I_J: begin
                            pc_we  = 1'b1;
                            pc_sel = 2'd2;
                            retire = 1'b1;
                            next   = FETCH;
                        end
                        I_JAL: begin
                            pc_we   = 1'b1;
                            pc_sel  = 2'd2;
                            reg_we  = 1'b1;
                            dst_sel = 2'd2;
                            wd_sel  = 2'd2;
                            retire  = 1'b1;
                            next    = FETCH;
                        end
                        I_JR: begin
                            pc_we  = 1'b1;
                            pc_sel = 2'd3;
                            retire = 1'b1;
                            next   = FETCH;
                        end
                        I_NOP, I_UND: begin
                            retire = 1'b1;
                            next   = FETCH;
                        end
                        default: next = EXEC;
                    endcase
                end
                EXEC: begin
                    case (ins)
                        I_SUBU, I_BEQ: alu_ctrl = 3'b001;
                        I_OR, I_ORI:   alu_ctrl = 3'b011;
                        I_LUI:         alu_ctrl = 3'b100;
                        default:       alu_ctrl = 3'b000;
                    endcase
                    alu_srcb = (ins == I_ORI) || (ins == I_LUI) || (ins == I_LW) ||
                               (ins == I_LH)  || (ins == I_SW);
                    ext_sign = (ins == I_LW) || (ins == I_LH) || (ins == I_SW) ||
                               (ins == I_BEQ);
                    case (ins)
                        I_BEQ: begin
                            pc_we  = zero;
                            pc_sel = 2'd1;
                            retire = 1'b1;
                            next   = FETCH;
                        end
                        I_LW, I_LH, I_SW: next = MEM;
                        default:          next = WB;
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (ins == I_SW);
                    half    = (ins == I_LH);
                    if (!mem_go) begin
                        next = MEM;
                    end else if (ins == I_SW) begin
                        retire = 1'b1;
                        next   = FETCH;
                    end else begin
                        next = WB;
                    end
                end
                WB: begin
                    reg_we  = 1'b1;
                    retire  = 1'b1;
                    dst_sel = is_rtype ? 2'd1 : 2'd0;
                    wd_sel  = ((ins == I_LW) || (ins == I_LH)) ? 2'd1 : 2'd0;
                    half    = (ins == I_LH);
                    next    = FETCH;
                end
                // Illegal codes: outputs stay 0 and the machine recovers.
                default: next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, func;
    logic       zero, mem_ready;

    logic       ir_we, pc_we, reg_we, alu_srcb, ext_sign, mem_req, mem_we, half, retire;
    logic [1:0] pc_sel, dst_sel, wd_sel;
    logic [2:0] alu_ctrl, st;

    logic       ir_we0, pc_we0, reg_we0, alu_srcb0, ext_sign0, mem_req0, mem_we0, half0, retire0;
    logic [1:0] pc_sel0, dst_sel0, wd_sel0;
    logic [2:0] alu_ctrl0, st0;

    multi_cycle_ctrl #(.USE_MEM_READY(1), .JAL_REG(31)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .dst_sel(dst_sel),
        .wd_sel(wd_sel), .alu_srcb(alu_srcb), .ext_sign(ext_sign), .alu_ctrl(alu_ctrl),
        .mem_req(mem_req), .mem_we(mem_we), .half(half), .retire(retire), .state_o(st)
    );

    // Second instance ignores mem_ready, which is tied low.
    multi_cycle_ctrl #(.USE_MEM_READY(0), .JAL_REG(31)) dut0 (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(1'b0),
        .ir_we(ir_we0), .pc_we(pc_we0), .pc_sel(pc_sel0), .reg_we(reg_we0), .dst_sel(dst_sel0),
        .wd_sel(wd_sel0), .alu_srcb(alu_srcb0), .ext_sign(ext_sign0), .alu_ctrl(alu_ctrl0),
        .mem_req(mem_req0), .mem_we(mem_we0), .half(half0), .retire(retire0), .state_o(st0)
    );

    always #5 clk = ~clk;

    // Output vector layout:
    // [17]ir_we [16]pc_we [15:14]pc_sel [13]reg_we [12:11]dst_sel [10:9]wd_sel
    // [8]alu_srcb [7]ext_sign [6:4]alu_ctrl [3]mem_req [2]mem_we [1]half [0]retire
    logic [17:0] obs, obs0;
    assign obs  = {ir_we, pc_we, pc_sel, reg_we, dst_sel, wd_sel, alu_srcb, ext_sign,
                   alu_ctrl, mem_req, mem_we, half, retire};
    assign obs0 = {ir_we0, pc_we0, pc_sel0, reg_we0, dst_sel0, wd_sel0, alu_srcb0, ext_sign0,
                   alu_ctrl0, mem_req0, mem_we0, half0, retire0};

    localparam logic [17:0] IRW  = 18'h20000;
    localparam logic [17:0] PCW  = 18'h10000;
    localparam logic [17:0] RWE  = 18'h02000;
    localparam logic [17:0] SRCB = 18'h00100;
    localparam logic [17:0] EXTS = 18'h00080;
    localparam logic [17:0] MREQ = 18'h00008;
    localparam logic [17:0] MWE  = 18'h00004;
    localparam logic [17:0] HALF = 18'h00002;
    localparam logic [17:0] RET  = 18'h00001;
    localparam logic [17:0] NONE = 18'h00000;
    localparam logic [17:0] ALL  = 18'h3FFFF;

    function automatic logic [17:0] psel(input logic [1:0] v); return {2'b0, v, 14'b0}; endfunction
    function automatic logic [17:0] dst (input logic [1:0] v); return {5'b0, v, 11'b0}; endfunction
    function automatic logic [17:0] wd  (input logic [1:0] v); return {7'b0, v, 9'b0};  endfunction
    function automatic logic [17:0] alu (input logic [2:0] v); return {11'b0, v, 4'b0}; endfunction

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check state and outputs of the selected
    // instance, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input bit use0, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic m, input logic [2:0] es,
                       input logic [17:0] ex, input logic [17:0] msk = ALL);
        op = o; func = f; zero = z; mem_ready = m;
        #1;
        if (use0) begin
            check({tag, ".state"}, 32'(st0), 32'(es));
            check({tag, ".out"}, 32'(obs0 & msk), 32'(ex & msk));
        end else begin
            check({tag, ".state"}, 32'(st), 32'(es));
            check({tag, ".out"}, 32'(obs & msk), 32'(ex & msk));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    localparam logic [17:0] FETCH_O = IRW | PCW | psel(2'd0);

    initial begin
        reset = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", 32'(st), 32'(S_F));
        check("rst.out", 32'(obs), 32'(NONE));
        check("rst.out0", 32'(obs0), 32'(NONE));
        reset = 1'b1;

        // addu
        cyc("addu.F", 0, 6'h00, 6'h21, 0, 0, S_F, FETCH_O);
        cyc("addu.D", 0, 6'h00, 6'h21, 0, 0, S_D, NONE);
        cyc("addu.E", 0, 6'h00, 6'h21, 0, 0, S_E, alu(3'b000));
        cyc("addu.W", 0, 6'h00, 6'h21, 0, 0, S_W, RWE | dst(2'd1) | wd(2'd0) | RET);

        // addu abandoned by reset in EXEC
        cyc("abrt.F", 0, 6'h00, 6'h21, 0, 0, S_F, FETCH_O);
        cyc("abrt.D", 0, 6'h00, 6'h21, 0, 0, S_D, NONE);
        #2;
        reset = 1'b0;
        #1;
        check("abrt.state", 32'(st), 32'(S_F));
        check("abrt.out", 32'(obs), 32'(NONE));
        @(posedge clk); #1;
        check("abrt.hold", 32'(obs), 32'(NONE));
        reset = 1'b1;
        #1;
        check("abrt.rel", 32'(obs), 32'(FETCH_O));
        @(posedge clk); #1;
        check("abrt.rel.state", 32'(st), 32'(S_D));
        do_reset();

        // beq taken, then not taken (pc_sel masked on the not-taken EXEC)
        cyc("beq1.F", 0, 6'h04, 6'h00, 1, 0, S_F, FETCH_O);
        cyc("beq1.D", 0, 6'h04, 6'h00, 1, 0, S_D, NONE);
        cyc("beq1.E", 0, 6'h04, 6'h00, 1, 0, S_E, PCW | psel(2'd1) | EXTS | alu(3'b001) | RET);
        cyc("beq0.F", 0, 6'h04, 6'h00, 0, 0, S_F, FETCH_O);
        cyc("beq0.D", 0, 6'h04, 6'h00, 0, 0, S_D, NONE);
        cyc("beq0.E", 0, 6'h04, 6'h00, 0, 0, S_E, EXTS | alu(3'b001) | RET, ALL & ~psel(2'd3));

        // lh with three stall cycles in MEM
        cyc("lh.F",  0, 6'h21, 6'h00, 0, 0, S_F, FETCH_O);
        cyc("lh.D",  0, 6'h21, 6'h00, 0, 0, S_D, NONE);
        cyc("lh.E",  0, 6'h21, 6'h00, 0, 0, S_E, alu(3'b000) | SRCB | EXTS);
        cyc("lh.M1", 0, 6'h21, 6'h00, 0, 0, S_M, MREQ | HALF);
        cyc("lh.M2", 0, 6'h21, 6'h00, 0, 0, S_M, MREQ | HALF);
        cyc("lh.M3", 0, 6'h21, 6'h00, 0, 0, S_M, MREQ | HALF);
        cyc("lh.M4", 0, 6'h21, 6'h00, 0, 1, S_M, MREQ | HALF);
        cyc("lh.W",  0, 6'h21, 6'h00, 0, 0, S_W, RWE | dst(2'd0) | wd(2'd1) | HALF | RET);
        cyc("lh.nx", 0, 6'h00, 6'h00, 0, 0, S_F, FETCH_O);

        // ori
        do_reset();
        cyc("ori.F", 0, 6'h0D, 6'h00, 0, 0, S_F, FETCH_O);
        cyc("ori.D", 0, 6'h0D, 6'h00, 0, 0, S_D, NONE);
        cyc("ori.E", 0, 6'h0D, 6'h00, 0, 0, S_E, alu(3'b011) | SRCB);
        cyc("ori.W", 0, 6'h0D, 6'h00, 0, 0, S_W, RWE | dst(2'd0) | wd(2'd0) | RET);

        // jr
        cyc("jr.F", 0, 6'h00, 6'h08, 0, 0, S_F, FETCH_O);
        cyc("jr.D", 0, 6'h00, 6'h08, 0, 0, S_D, PCW | psel(2'd3) | RET);

        // sw on the instance that ignores mem_ready
        do_reset();
        cyc("sw0.F", 1, 6'h2B, 6'h00, 0, 0, S_F, FETCH_O);
        cyc("sw0.D", 1, 6'h2B, 6'h00, 0, 0, S_D, NONE);
        cyc("sw0.E", 1, 6'h2B, 6'h00, 0, 0, S_E, alu(3'b000) | SRCB | EXTS);
        cyc("sw0.M", 1, 6'h2B, 6'h00, 0, 0, S_M, MREQ | MWE | RET);
        cyc("sw0.nx", 1, 6'h00, 6'h00, 0, 0, S_F, FETCH_O);

        // jal, then an undecoded opcode
        do_reset();
        cyc("jal.F", 0, 6'h03, 6'h00, 0, 0, S_F, FETCH_O);
        cyc("jal.D", 0, 6'h03, 6'h00, 0, 0, S_D, PCW | psel(2'd2) | RWE | dst(2'd2) | wd(2'd2) | RET);
        cyc("und.F", 0, 6'h3F, 6'h00, 0, 0, S_F, FETCH_O);
        cyc("und.D", 0, 6'h3F, 6'h00, 0, 0, S_D, RET);
        cyc("und.nx", 0, 6'h00, 6'h00, 0, 0, S_F, FETCH_O);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
